// File: rtl/trans_layer_nch.sv
// trans_layer_nch: main FIFO fanning out to NCH channel FIFOs, routed by the
// top data bits, with threshold flow control and a sticky-error control FSM.
module trans_layer_nch #(
    parameter int DW      = 6,
    parameter int NCH     = 4,
    parameter int MAIN_AW = 3,
    parameter int CH_AW   = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     init,
    input  logic [2*(MAIN_AW+1)-1:0] umbral_main,
    input  logic [2*(CH_AW+1)-1:0]   umbral_ch,
    input  logic [DW-1:0]            data_in,
    input  logic                     push_main,
    input  logic [NCH-1:0]           pop,
    output logic [NCH*DW-1:0]        data_out,
    output logic [NCH-1:0]           valid_out,
    output logic                     main_full,
    output logic                     main_empty,
    output logic                     main_almost_full,
    output logic                     main_almost_empty,
    output logic [NCH-1:0]           ch_full,
    output logic [NCH-1:0]           ch_empty,
    output logic [NCH-1:0]           ch_almost_full,
    output logic [NCH-1:0]           ch_almost_empty,
    output logic                     error_out,
    output logic                     active_out,
    output logic                     idle_out,
    output logic [2:0]               state
);

    localparam int SW = $clog2(NCH);
    localparam int MW = MAIN_AW + 1;
    localparam int CW = CH_AW + 1;
    localparam int MD = 1 << MAIN_AW;
    localparam int CD = 1 << CH_AW;

    localparam logic [2:0] S_RESET  = 3'd0;
    localparam logic [2:0] S_INIT   = 3'd1;
    localparam logic [2:0] S_IDLE   = 3'd2;
    localparam logic [2:0] S_ACTIVE = 3'd3;
    localparam logic [2:0] S_ERROR  = 3'd4;

    logic [2:0] state_q, state_d;
    logic err_q, err_d, act_q, act_d, idle_q, idle_d;

    logic [MW-1:0] main_hi_q, main_hi_d, main_lo_q, main_lo_d;
    logic [CW-1:0] ch_hi_q, ch_hi_d, ch_lo_q, ch_lo_d;

    logic [DW-1:0]      main_mem_q [MD];
    logic [DW-1:0]      main_mem_d [MD];
    logic [MAIN_AW-1:0] main_wr_q, main_wr_d, main_rd_q, main_rd_d;
    logic [MW-1:0]      main_cnt_q, main_cnt_d;

    logic [DW-1:0]    ch_mem_q [NCH][CD];
    logic [DW-1:0]    ch_mem_d [NCH][CD];
    logic [CH_AW-1:0] ch_wr_q [NCH];
    logic [CH_AW-1:0] ch_wr_d [NCH];
    logic [CH_AW-1:0] ch_rd_q [NCH];
    logic [CH_AW-1:0] ch_rd_d [NCH];
    logic [CW-1:0]    ch_cnt_q [NCH];
    logic [CW-1:0]    ch_cnt_d [NCH];

    logic [DW-1:0]  dout_q [NCH];
    logic [DW-1:0]  dout_d [NCH];
    logic [NCH-1:0] valid_q, valid_d;

    logic           op_en, flush, push_ok, overflow, xfer, any_busy;
    logic [DW-1:0]  head;
    logic [SW-1:0]  head_ch;
    logic [NCH-1:0] ch_in, ch_out;

    assign main_full         = (main_cnt_q == MW'(MD));
    assign main_empty        = (main_cnt_q == '0);
    assign main_almost_full  = (main_cnt_q >= main_hi_q);
    assign main_almost_empty = (main_cnt_q <= main_lo_q);

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        assign ch_full[g]         = (ch_cnt_q[g] == CW'(CD));
        assign ch_empty[g]        = (ch_cnt_q[g] == '0);
        assign ch_almost_full[g]  = (ch_cnt_q[g] >= ch_hi_q);
        assign ch_almost_empty[g] = (ch_cnt_q[g] <= ch_lo_q);
        assign data_out[g*DW +: DW] = dout_q[g];
    end

    assign valid_out  = valid_q;
    assign state      = state_q;
    assign error_out  = err_q;
    assign active_out = act_q;
    assign idle_out   = idle_q;

    always_comb begin
        op_en    = !init && (state_q == S_IDLE || state_q == S_ACTIVE);
        flush    = init || state_q == S_RESET || state_q == S_INIT;
        head     = main_mem_q[main_rd_q];
        head_ch  = head[DW-1 -: SW];
        // Head-of-line: only the head word may move, so a blocked head stalls all.
        xfer     = op_en && !main_empty
                   && !ch_almost_full[head_ch] && !ch_full[head_ch];
        push_ok  = op_en && push_main && !main_full;
        overflow = op_en && push_main && main_full;
        any_busy = !main_empty || !(&ch_empty);
        for (int i = 0; i < NCH; i++) begin
            ch_in[i]  = xfer && (head_ch == SW'(i));
            ch_out[i] = op_en && pop[i] && !ch_empty[i];
        end
    end

    always_comb begin
        state_d = state_q;
        if (init) begin
            state_d = S_INIT;
        end else begin
            case (state_q)
                S_RESET:  state_d = S_INIT;
                S_INIT:   state_d = S_IDLE;
                S_IDLE: begin
                    if (overflow)      state_d = S_ERROR;
                    else if (any_busy) state_d = S_ACTIVE;
                end
                S_ACTIVE: begin
                    if (overflow)       state_d = S_ERROR;
                    else if (!any_busy) state_d = S_IDLE;
                end
                S_ERROR:  state_d = S_ERROR;
                default:  state_d = S_RESET;
            endcase
        end
        err_d  = (state_d == S_ERROR);
        act_d  = (state_d == S_ACTIVE);
        idle_d = (state_d == S_IDLE);
    end

    always_comb begin
        main_hi_d = main_hi_q;
        main_lo_d = main_lo_q;
        ch_hi_d   = ch_hi_q;
        ch_lo_d   = ch_lo_q;
        if (init || state_q == S_INIT) begin
            main_hi_d = umbral_main[2*MW-1 -: MW];
            main_lo_d = umbral_main[MW-1:0];
            ch_hi_d   = umbral_ch[2*CW-1 -: CW];
            ch_lo_d   = umbral_ch[CW-1:0];
        end
    end

    always_comb begin
        main_mem_d = main_mem_q;
        main_wr_d  = main_wr_q;
        main_rd_d  = main_rd_q;
        main_cnt_d = main_cnt_q;
        if (flush) begin
            main_wr_d  = '0;
            main_rd_d  = '0;
            main_cnt_d = '0;
        end else begin
            if (push_ok) begin
                main_mem_d[main_wr_q] = data_in;
                main_wr_d = main_wr_q + 1'b1;
            end
            if (xfer) begin
                main_rd_d = main_rd_q + 1'b1;
            end
            case ({push_ok, xfer})
                2'b10:   main_cnt_d = main_cnt_q + 1'b1;
                2'b01:   main_cnt_d = main_cnt_q - 1'b1;
                default: main_cnt_d = main_cnt_q;
            endcase
        end
    end

    always_comb begin
        ch_mem_d = ch_mem_q;
        ch_wr_d  = ch_wr_q;
        ch_rd_d  = ch_rd_q;
        ch_cnt_d = ch_cnt_q;
        dout_d   = dout_q;
        valid_d  = '0;
        for (int i = 0; i < NCH; i++) begin
            if (flush) begin
                ch_wr_d[i]  = '0;
                ch_rd_d[i]  = '0;
                ch_cnt_d[i] = '0;
            end else begin
                if (ch_in[i]) begin
                    ch_mem_d[i][ch_wr_q[i]] = head;
                    ch_wr_d[i] = ch_wr_q[i] + 1'b1;
                end
                if (ch_out[i]) begin
                    dout_d[i]  = ch_mem_q[i][ch_rd_q[i]];
                    valid_d[i] = 1'b1;
                    ch_rd_d[i] = ch_rd_q[i] + 1'b1;
                end
                case ({ch_in[i], ch_out[i]})
                    2'b10:   ch_cnt_d[i] = ch_cnt_q[i] + 1'b1;
                    2'b01:   ch_cnt_d[i] = ch_cnt_q[i] - 1'b1;
                    default: ch_cnt_d[i] = ch_cnt_q[i];
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_RESET;
            err_q      <= 1'b0;
            act_q      <= 1'b0;
            idle_q     <= 1'b0;
            main_hi_q  <= MW'(MD - 1);
            main_lo_q  <= MW'(1);
            ch_hi_q    <= CW'(CD - 1);
            ch_lo_q    <= CW'(1);
            main_wr_q  <= '0;
            main_rd_q  <= '0;
            main_cnt_q <= '0;
            ch_wr_q    <= '{default: '0};
            ch_rd_q    <= '{default: '0};
            ch_cnt_q   <= '{default: '0};
            dout_q     <= '{default: '0};
            valid_q    <= '0;
        end else begin
            state_q    <= state_d;
            err_q      <= err_d;
            act_q      <= act_d;
            idle_q     <= idle_d;
            main_hi_q  <= main_hi_d;
            main_lo_q  <= main_lo_d;
            ch_hi_q    <= ch_hi_d;
            ch_lo_q    <= ch_lo_d;
            main_wr_q  <= main_wr_d;
            main_rd_q  <= main_rd_d;
            main_cnt_q <= main_cnt_d;
            ch_wr_q    <= ch_wr_d;
            ch_rd_q    <= ch_rd_d;
            ch_cnt_q   <= ch_cnt_d;
            dout_q     <= dout_d;
            valid_q    <= valid_d;
        end
    end

    // Storage needs no reset: the counts alone decide what is valid.
    always_ff @(posedge clk) begin
        main_mem_q <= main_mem_d;
        ch_mem_q   <= ch_mem_d;
    end

endmodule

// File: doc/trans_layer_nch.md
# trans_layer_nch

Parametrised transaction-layer block: one main input FIFO feeding NCH per-channel output FIFOs, with word routing by the top data bits, threshold-based flow control and a RESET/INIT/IDLE/ACTIVE/ERROR control FSM. It generalises the fixed two-output (D0/D1) transaction layer to N channels with configurable data width, FIFO depths and run-time thresholds. It adds head-of-line backpressure and a sticky error recovered through `init`. It sits between the upstream packet source (`push_main`) and the per-lane consumers (`pop[i]`).

## Interface
- DW, 6: data width.
- NCH, 4: output channels, power of 2, ≥2; SW = log2(NCH).
- MAIN_AW, 3: main FIFO address width; MAIN_DEPTH = 2^MAIN_AW.
- CH_AW, 2: channel FIFO address width; CH_DEPTH = 2^CH_AW.

- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-high.
- init  in  1  enter INIT: flush FIFOs, load thresholds.
- umbral_main  in  2*(MAIN_AW+1)  {hi, lo} main thresholds (hi in upper half).
- umbral_ch  in  2*(CH_AW+1)  {hi, lo} thresholds shared by all channels.
- data_in  in  DW  word to push.
- push_main  in  1  push request.
- pop  in  NCH  per-channel pop request.
- data_out  out  NCH*DW  channel i at [i*DW +: DW], registered.
- valid_out  out  NCH  data_out[i] valid this cycle.
- main_full, main_empty, main_almost_full, main_almost_empty  out  1 each.
- ch_full, ch_empty, ch_almost_full, ch_almost_empty  out  NCH each.
- error_out, active_out, idle_out  out  1 each.
- state  out  3  RESET=0, INIT=1, IDLE=2, ACTIVE=3, ERROR=4.

## Operation
- Routing: channel = word[DW-1 -: SW].
- Counts are MAIN_AW+1 and CH_AW+1 bits wide; pointers wrap modulo depth.
- almost_full = count ≥ hi; almost_empty = count ≤ lo; full = count == depth; empty = count == 0.
- Transfer: at most one word per cycle, main head → channel c, when main non-empty, state ∈ {IDLE, ACTIVE}, and ch_almost_full[c] = 0 and ch_full[c] = 0.
- A blocked head stalls all following words (head-of-line blocking); order is preserved per channel and globally.
- Push: accepted only in IDLE/ACTIVE. Push while main_full → word dropped, next state ERROR, regardless of a same-cycle transfer out. Push and transfer in the same cycle → count unchanged.
- Pop: in IDLE/ACTIVE, with channel non-empty → data_out[i] ← head, valid_out[i] = 1 for one cycle.
  - Pop on an empty channel → ignored, valid_out[i] = 0, not an error.
  - Pop and transfer into the same channel in the same cycle → both occur.
  - data_out[i] holds its last value when not popping.
- FSM priority: reset > init > other transitions.
  - reset=1 → RESET: FIFOs cleared; thresholds default to hi = depth-1, lo = 1.
  - RESET, reset=0 → INIT.
  - Any state, init=1 → INIT.
  - INIT: FIFOs flushed, thresholds sampled every cycle; init=0 → IDLE.
  - IDLE: any FIFO non-empty → ACTIVE.
  - ACTIVE: all FIFOs empty → IDLE; overflow → ERROR.
  - IDLE overflow is impossible.
  - ERROR: sticky; push/pop/transfer blocked; contents held. Exit only via init or reset.
- Flag outputs: error_out = (state == ERROR), active_out = (state == ACTIVE), idle_out = (state == IDLE); registered.

## Timing
- Reset values: state = RESET, data_out = 0, valid_out = 0, error/active/idle = 0, main_empty = 1, ch_empty = all 1s, main/ch_almost_empty = 1, all full/almost_full = 0.
- Flags are combinational from registered counts and thresholds.
- Latency: push sampled at edge k → word in main after k. Earliest transfer is at edge k+1. Earliest pop is at edge k+2, with valid_out high after k+2.
- State updates one edge after its cause; overflow at edge k → error_out = 1 after edge k.
- Reset asserted mid-operation → next edge everything returns to reset values; in-flight words are lost.

## Test plan
- Reset/boot: reset=1 for 2 cycles → reset values above. Release with init=0 → state 1 then 2; idle_out = 1.
- Routing (defaults, umbral_main = 8'h71, umbral_ch = 6'h19): push 000001, 010010, 100011, 110100; 4 cycles later pop = 4'hF → data_out = {110100, 100011, 010010, 000001}, valid_out = 4'hF for 1 cycle. active_out = 1 while occupied, idle_out = 1 after drain.
- Backpressure (ch hi = 3): push 5 words to ch0, no pops → ch0 count = 3, ch_almost_full[0] = 1, main count = 2. One pop on ch0 → transfer resumes next cycle.
- Head-of-line: ch1 held at hi, main head for ch1 then a ch2 word → ch2 word not delivered until ch1 is popped; order preserved.
- Overflow/recovery (ch hi = 0 blocks transfers): push 9 words → 8 stored, main_full = 1. 9th push → error_out = 1, state 4; further push/pop ignored. init pulse → state 1, FIFOs empty, then IDLE.
- Mid-op reset: reset during ACTIVE with data in flight → next cycle all FIFOs empty, data_out = 0, state 0.
